// File: rtl/router_pkg.sv
// Shared types and constants for the router ingress block.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_FIRST,
        ST_LOAD_DATA,
        ST_LOAD_PARITY,
        ST_CHECK,
        ST_DROP
    } state_e;

    localparam int unsigned MAX_LEN      = 63;
    localparam int unsigned LEN_W        = $clog2(MAX_LEN + 1);
    localparam int unsigned TIMEOUT      = 30;
    localparam int unsigned TO_W         = 5;
    localparam int unsigned NUM_DEST     = 3;
    localparam logic [1:0]  ADDR_INVALID = 2'd3;

    // Header field positions: [7:2] payload length, [1:0] destination
    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_DEST_MSB = 1;
    localparam int unsigned HDR_DEST_LSB = 0;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    function automatic logic [1:0] hdr_dest(input logic [7:0] hdr);
        return hdr[HDR_DEST_MSB:HDR_DEST_LSB];
    endfunction

endpackage

// File: rtl/router_timeout.sv
// Per-destination consumer watchdog: flags a FIFO whose data sits unread
// for TIMEOUT consecutive cycles.
module router_timeout
    import router_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic fifo_empty_i,
    input  logic read_en_i,
    output logic soft_rst_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            stall;

    assign stall = !fifo_empty_i && !read_en_i;

    // Count stalled cycles; the pulse is raised during the TIMEOUT-th one.
    always_comb begin
        cnt_d      = '0;
        soft_rst_o = 1'b0;
        if (stall) begin
            if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                soft_rst_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/router_ingress.sv
// Ingress framer: validates a header, forwards header/payload/parity bytes
// to one of three output FIFOs, checks parity and reports errors.
module router_ingress
    import router_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                pkt_valid,
    input  logic [7:0]          data_in,
    input  logic [NUM_DEST-1:0] fifo_full,
    input  logic [NUM_DEST-1:0] fifo_empty,
    input  logic [NUM_DEST-1:0] read_en,
    output logic                busy,
    output logic [NUM_DEST-1:0] wr_en,
    output logic                lfd_state,
    output logic [7:0]          dout,
    output logic                parity_done,
    output logic                err,
    output logic [NUM_DEST-1:0] soft_rst
);

    state_e             state_q, state_d;
    logic [7:0]         hdr_q, hdr_d;
    logic [1:0]         dest_q, dest_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         par_q, par_d;
    logic               mism_q, mism_d;
    logic               err_q, err_d;

    logic [NUM_DEST-1:0] dest_oh;
    logic                full_sel;
    logic                soft_sel;

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_timeout
        router_timeout u_timeout (
            .clk          (clk),
            .rst          (rst),
            .fifo_empty_i (fifo_empty[g]),
            .read_en_i    (read_en[g]),
            .soft_rst_o   (soft_rst[g])
        );
    end

    assign dest_oh  = NUM_DEST'(1) << dest_q;
    assign full_sel = |(fifo_full & dest_oh);
    assign soft_sel = |(soft_rst & dest_oh);

    // Next-state and write-side outputs; writes are gated by the selected
    // FIFO's full and flush flags so a stalled or aborted byte is never written.
    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        dest_d      = dest_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        mism_d      = mism_q;
        err_d       = 1'b0;
        busy        = 1'b0;
        wr_en       = '0;
        lfd_state   = 1'b0;
        dout        = '0;
        parity_done = 1'b0;
        err         = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    if (hdr_dest(data_in) == ADDR_INVALID || hdr_len(data_in) == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        hdr_d   = data_in;
                        dest_d  = hdr_dest(data_in);
                        len_d   = hdr_len(data_in);
                        cnt_d   = '0;
                        par_d   = data_in;
                        mism_d  = 1'b0;
                        state_d = ST_LOAD_FIRST;
                    end
                end
            end

            ST_LOAD_FIRST: begin
                busy = 1'b1;
                if (soft_sel) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (!full_sel) begin
                    wr_en     = dest_oh;
                    lfd_state = 1'b1;
                    dout      = hdr_q;
                    state_d   = ST_LOAD_DATA;
                end
            end

            ST_LOAD_DATA: begin
                busy = full_sel;
                if (soft_sel || !pkt_valid) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (!full_sel) begin
                    wr_en = dest_oh;
                    dout  = data_in;
                    par_d = par_q ^ data_in;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = ST_LOAD_PARITY;
                    end
                end
            end

            ST_LOAD_PARITY: begin
                busy = full_sel;
                if (soft_sel || !pkt_valid) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (!full_sel) begin
                    wr_en   = dest_oh;
                    dout    = data_in;
                    mism_d  = (data_in != par_q);
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                busy        = 1'b1;
                parity_done = 1'b1;
                err         = err_q | mism_q;
                state_d     = ST_IDLE;
            end

            ST_DROP: begin
                if (!pkt_valid) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            dest_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            par_q   <= '0;
            mism_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_router_ingress.sv
// Randomized self-checking bench for router_ingress with a packet-level
// reference model (expected write list, error/parity_done counts) and a
// run-length model for the consumer timeouts.
module tb_router_ingress;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_en;
    logic       busy;
    logic [2:0] wr_en;
    logic       lfd_state;
    logic [7:0] dout;
    logic       parity_done;
    logic       err;
    logic [2:0] soft_rst;

    router_ingress dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_valid   (pkt_valid),
        .data_in     (data_in),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .read_en     (read_en),
        .busy        (busy),
        .wr_en       (wr_en),
        .lfd_state   (lfd_state),
        .dout        (dout),
        .parity_done (parity_done),
        .err         (err),
        .soft_rst    (soft_rst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] dest;
        logic       lfd;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  err_seen = 0;
    int  pd_seen  = 0;
    int  wr_seen  = 0;

    // Write monitor: every FIFO write must be the next expected byte
    always @(negedge clk) begin
        wr_t e;
        if (err)         err_seen++;
        if (parity_done) pd_seen++;
        if (wr_en != 3'b000) begin
            wr_seen++;
            check_eq("wr_onehot", $countones(wr_en), 1);
            check_eq("wr_to_full", wr_en & fifo_full, 0);
            if (exp_q.size() == 0) begin
                check_eq("wr_extra", wr_en, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_byte", {wr_en, lfd_state, dout},
                         {3'b001 << e.dest, e.lfd, e.data});
            end
        end
    end

    logic [7:0] pay[64];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // mode 0: full packet; 1: pkt_valid drops after k payload bytes;
    // 2: reset after k payload bytes; 3: bad header then two dropped bytes.
    // par_xor corrupts the parity byte; stall_at forces 4 full cycles after
    // that many payload bytes.
    task automatic send_pkt(input logic [7:0] hdr, input int mode, input int k,
                            input logic [7:0] par_xor, input int full_pct, input int stall_at);
        logic [7:0] stream[66];
        logic [7:0] par;
        logic [1:0] dv;
        int L, nb, n_wr, e_err, e_pd;
        int err0, pd0, wr0;
        int idx, stall_left, cyc;
        logic done;
        L  = int'(hdr[7:2]);
        dv = hdr[1:0];
        par = hdr;
        stream[0] = hdr;
        for (int i = 0; i < L; i++) begin
            stream[i+1] = pay[i];
            par = par ^ pay[i];
        end
        stream[L+1] = par ^ par_xor;
        nb = L + 2;
        case (mode)
            0:       begin n_wr = nb;    e_err = (par_xor != 0) ? 1 : 0; e_pd = 1; end
            1:       begin n_wr = k + 1; e_err = 1; e_pd = 0; end
            2:       begin n_wr = k + 1; e_err = 0; e_pd = 0; end
            default: begin n_wr = 0;     e_err = 1; e_pd = 0; end
        endcase
        for (int i = 0; i < n_wr; i++) begin
            exp_q.push_back(wr_t'{dest: dv, lfd: (i == 0), data: stream[i]});
        end
        err0 = err_seen; pd0 = pd_seen; wr0 = wr_seen;
        idx = 0; stall_left = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 800) begin
            pkt_valid = 1'b1;
            data_in   = (mode == 3 && idx > 0) ? 8'($urandom) : stream[idx];
            for (int j = 0; j < 3; j++) fifo_full[j] = ($urandom_range(99) < full_pct);
            if (stall_left > 0) fifo_full[dv] = 1'b1;
            @(negedge clk);
            if (stall_left > 0) begin
                check_eq("stall_busy", busy, 1);
                stall_left--;
            end else if (!busy) begin
                idx++;
                if (mode == 0 && idx == nb) done = 1'b1;
                if ((mode == 1 || mode == 2) && idx == k + 1) done = 1'b1;
                if (mode == 3 && idx == 3) done = 1'b1;
                if (stall_at > 0 && idx == stall_at + 1) stall_left = 4;
            end
            next_cycle();
            cyc++;
        end
        check_eq("pkt_budget", done, 1);
        if (mode == 2) begin
            #2 rst = 1'b0;
            #1 check_eq("rst_outs", {busy, wr_en, lfd_state, dout, parity_done, err, soft_rst}, 0);
            pkt_valid = 1'b0;
            fifo_full = '0;
            next_cycle();
            rst = 1'b1;
        end
        pkt_valid = 1'b0;
        fifo_full = '0;
        repeat (4) next_cycle();
        check_eq("pkt_err", err_seen - err0, e_err);
        check_eq("pkt_pdone", pd_seen - pd0, e_pd);
        check_eq("pkt_nwr", wr_seen - wr0, n_wr);
        check_eq("pkt_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Timeout model: a channel pulses on every 30th consecutive stalled cycle
    int         run[3];
    logic [2:0] last_soft;

    task automatic to_cycle(input logic [2:0] emp, input logic [2:0] rd);
        logic [2:0] exp_soft;
        fifo_empty = emp;
        read_en    = rd;
        for (int i = 0; i < 3; i++) begin
            if (emp[i] || rd[i]) run[i] = 0;
            else                 run[i] = run[i] + 1;
            exp_soft[i] = (run[i] > 0) && (run[i] % 30 == 0);
        end
        @(negedge clk);
        last_soft = soft_rst;
        check_eq("soft_rst", soft_rst, exp_soft);
        next_cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hit, err0, pd0, wr0, L, r;
        logic [1:0] d;
        rst = 1'b0; pkt_valid = 1'b0; data_in = '0;
        fifo_full = '0; fifo_empty = 3'b111; read_en = '0;
        #2 check_eq("reset_outs", {busy, wr_en, lfd_state, dout, parity_done, err, soft_rst}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        next_cycle();

        // Reference packet, correct then corrupted parity
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_pkt(8'h0D, 0, 0, 8'h00, 0, 0);
        send_pkt(8'h0D, 0, 0, 8'h0D, 0, 0);
        // Invalid destination, zero length
        send_pkt(8'h07, 3, 0, 8'h00, 0, 0);
        send_pkt(8'h01, 3, 0, 8'h00, 0, 0);
        // Back-pressure after the 2nd payload byte, L=5 dest 0
        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
        send_pkt({6'd5, 2'd0}, 0, 0, 8'h00, 0, 2);
        // Reset mid-packet, then a clean packet
        send_pkt({6'd6, 2'd1}, 2, 2, 8'h00, 0, 0);
        send_pkt({6'd4, 2'd2}, 0, 0, 8'h00, 0, 0);
        // Source abort, min and max length
        send_pkt({6'd4, 2'd2}, 1, 2, 8'h00, 0, 0);
        send_pkt({6'd1, 2'd0}, 0, 0, 8'h00, 30, 0);
        send_pkt({6'd63, 2'd1}, 0, 0, 8'h00, 20, 0);

        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
            L = ($urandom_range(7) == 0) ? 63 : int'($urandom_range(10, 1));
            d = 2'($urandom_range(2));
            r = int'($urandom_range(9));
            if (r <= 5)      send_pkt({6'(L), d}, 0, 0, (r == 5) ? 8'($urandom_range(255, 1)) : 8'h00, 25, 0);
            else if (r <= 7) send_pkt({6'(L), d}, 1, int'($urandom_range(L, 1)), 8'h00, 25, 0);
            else if (r == 8) send_pkt({6'(L), d}, 2, int'($urandom_range(L, 1)), 8'h00, 25, 0);
            else if ($urandom_range(1) == 0) send_pkt({6'(L), 2'd3}, 3, 0, 8'h00, 25, 0);
            else             send_pkt({6'd0, d}, 3, 0, 8'h00, 25, 0);
        end

        // Consumer timeout on dest 2 while its packet is stalled in LOAD_FIRST;
        // full drops on the timeout cycle, which must still not write.
        err0 = err_seen; pd0 = pd_seen; wr0 = wr_seen; hit = 0;
        fifo_full = 3'b100; fifo_empty = 3'b011; read_en = '0;
        for (int c = 1; c <= 40; c++) begin
            pkt_valid = (hit == 0);
            data_in   = (c == 1) ? 8'h16 : 8'hA5;
            if (c == 30) fifo_full = '0;
            @(negedge clk);
            if (hit == 0) begin
                if (c > 1) check_eq("soft_stall_busy", busy, 1);
                if (soft_rst[2]) hit = c;
            end
            next_cycle();
        end
        pkt_valid = 1'b0; fifo_full = '0; fifo_empty = 3'b111;
        repeat (4) next_cycle();
        check_eq("soft_abort_at", hit, 30);
        check_eq("soft_abort_err", err_seen - err0, 1);
        check_eq("soft_abort_pd", pd_seen - pd0, 0);
        check_eq("soft_abort_nwr", wr_seen - wr0, 0);

        // Timeouts: clean start, 30-cycle pulse, read on cycle 29, random
        for (int i = 0; i < 3; i++) run[i] = 0;
        to_cycle(3'b111, 3'b000);
        hit = 0;
        for (int c = 1; c <= 32; c++) begin
            to_cycle(3'b011, 3'b000);
            if (last_soft[2] && hit == 0) hit = c;
        end
        check_eq("to_pulse_at", hit, 30);
        to_cycle(3'b111, 3'b000);
        hit = 0;
        for (int c = 1; c <= 40; c++) begin
            to_cycle(3'b011, (c == 29) ? 3'b100 : 3'b000);
            if (last_soft[2] && hit == 0) hit = c;
        end
        check_eq("to_read_suppress", hit, 59 - 29 > 40 - 29 ? 0 : 59);
        for (int c = 0; c < 400; c++) begin
            logic [2:0] e, rd;
            for (int i = 0; i < 3; i++) begin
                e[i]  = ($urandom_range(19) == 0);
                rd[i] = ($urandom_range(24) == 0);
            end
            to_cycle(e, rd);
        end
        fifo_empty = 3'b111; read_en = '0;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_ingress.md
ROUTER_INGRESS -- requirements
Module: router_ingress

Interface
REQ-001 clk  in  1  sole clock, all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 pkt_valid  in  1  source qualifies data_in; high from header through parity byte.
REQ-004 data_in  in  8  byte stream: header, payload, parity.
REQ-005 fifo_full  in  3  per-destination full flags from the three output FIFOs.
REQ-006 fifo_empty  in  3  per-destination empty flags.
REQ-007 read_en  in  3  per-destination consumer read strobes.
REQ-008 busy  out  1  source SHALL hold data_in stable while high.
REQ-009 wr_en  out  3  one-hot FIFO write strobe.
REQ-010 lfd_state  out  1  marks the header byte of a packet; shared by all FIFOs.
REQ-011 dout  out  8  byte to the FIFOs.
REQ-012 parity_done  out  1  one-cycle pulse after the parity byte is written.
REQ-013 err  out  1  one-cycle pulse on parity mismatch, bad header or abort.
REQ-014 soft_rst  out  3  one-cycle per-FIFO flush pulse on consumer timeout.

Function
REQ-015 Header format SHALL be: [7:2] payload length L (1..63), [1:0] destination (0..2); a packet is header, L payload bytes, 1 parity byte (XOR of header and all payload bytes).
REQ-016 A byte SHALL be accepted on an edge where pkt_valid=1 and busy=0; write outputs are combinational from registered state, so an accepted byte is written to the FIFO on that same edge.
REQ-017 IDLE: busy=0; valid header with pkt_valid=1 -> register header, dest, L; clear byte counter; init running parity to header; go LOAD_FIRST.
REQ-018 IDLE with destination 3 or L=0 -> err pulse, go DROP; DROP keeps busy=0, writes nothing, returns to IDLE on the first cycle pkt_valid=0.
REQ-019 LOAD_FIRST: busy=1; when fifo_full[dest]=0, assert wr_en[dest], lfd_state=1, dout=registered header, go LOAD_DATA; otherwise stay.
REQ-020 LOAD_DATA: busy=fifo_full[dest]; each accepted byte asserts wr_en[dest], dout=data_in, lfd_state=0; XOR into parity; increment counter; after the L-th byte go LOAD_PARITY.
REQ-021 LOAD_PARITY: busy=fifo_full[dest]; on acceptance, write the byte and compare it with the running parity; go CHECK.
REQ-022 CHECK: busy=1, no write; parity_done=1; err=1 if mismatch; go IDLE next cycle.
REQ-023 fifo_full rising mid-packet SHALL stall without loss or duplication; the held byte is written on the first edge with full=0.
REQ-024 pkt_valid=0 in LOAD_DATA or LOAD_PARITY -> err pulse, go IDLE; bytes already written remain written.
REQ-025 soft_rst[dest] during LOAD_FIRST, LOAD_DATA or LOAD_PARITY -> abort to IDLE with err pulse; no write occurs on that edge.
REQ-026 Timeout i: 5-bit counter increments each cycle fifo_empty[i]=0 and read_en[i]=0, and clears on read_en[i]=1 or fifo_empty[i]=1.
REQ-027 When the timeout counter reaches 30, soft_rst[i] pulses for one cycle and the counter clears; the three channels are independent.
REQ-028 wr_en SHALL never be asserted to a FIFO whose fifo_full=1, and never more than one bit at a time.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, counters and parity to 0, and all outputs to 0 (busy, wr_en, lfd_state, dout, parity_done, err, soft_rst).
REQ-030 Reset mid-packet discards the packet; the first edge after release evaluates data_in as a header.

Structure
REQ-031 Shared package router_pkg SHALL hold the state enumeration, MAX_LEN=63, TIMEOUT=30, ADDR_INVALID=2'd3, and the header field positions.
REQ-032 The timeout logic SHALL be a sub-module router_timeout, instantiated three times.

Verification
REQ-033 Header 8'h0D (L=3, dest 1), payload 11,22,33, parity 8'h0D^8'h11^8'h22^8'h33 -> five writes on wr_en=3'b010, lfd_state only on the first, parity_done pulse, err=0.
REQ-034 Same packet with parity byte 8'h00 -> five writes, parity_done and err pulse together in CHECK.
REQ-035 Header 8'h07 (dest 3) -> err pulse, zero writes, IDLE after pkt_valid falls.
REQ-036 fifo_full[0]=1 for 4 cycles after the 2nd payload byte of an L=5 dest-0 packet -> busy=1 for those 4 cycles, 7 total writes, byte order preserved.
REQ-037 fifo_empty[2]=0, read_en[2]=0 for 30 cycles -> soft_rst[2] pulse on the 30th; a read_en[2] at cycle 29 suppresses it.
REQ-038 rst asserted after the 2nd payload byte -> all outputs 0 immediately; a new packet after release completes cleanly.
